subservient_loader: RTL and testbench
=====================================

// Module: subservient_loader
// PURPOSE
//  Boot sequencer for the subservient SoC. Holds the CPU core in reset and owns the SRAM write port.
//  Zeroes the register-file region of SRAM, then receives a length-prefixed, checksummed program
//  over a byte stream and writes it to SRAM from address 0. On success it hands the SRAM port to
//  the core and releases core reset. Sits between subservient_core's o_sram_* port and the SRAM macro.
// PARAMETERS
//  memsize   512              SRAM size in bytes (power of 2)
//  aw        $clog2(memsize)  SRAM address width
//  RF_BYTES  256              bytes at top of SRAM reserved for RF/CSRs; program limit = memsize-RF_BYTES
//  CLEAR_RF  1                1: zero the RF region after reset; 0: skip the CLEAR state
// PORTS
//  i_clk          in   1   clock
//  i_rst_n        in   1   synchronous reset, active low
//  i_rx_data      in   8   program byte stream data
//  i_rx_valid     in   1   stream byte valid
//  o_rx_ready     out  1   loader accepts the byte (transfer = valid & ready)
//  o_core_rst     out  1   reset to the core; 1 until the load succeeds
//  o_done         out  1   load complete, core running (sticky)
//  o_err          out  1   length or checksum failure (sticky until reset)
//  i_core_waddr   in   aw  core SRAM write address
//  i_core_wdata   in   8   core SRAM write data
//  i_core_wen     in   1   core SRAM write enable
//  i_core_raddr   in   aw  core SRAM read address
//  o_sram_waddr   out  aw  SRAM write address (loader or core)
//  o_sram_wdata   out  8   SRAM write data
//  o_sram_wen     out  1   SRAM write enable
//  o_sram_raddr   out  aw  SRAM read address = i_core_raddr (combinational, always)
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge): state=CLEAR (LEN_LO if CLEAR_RF=0); o_core_rst=1, o_done=0,
//   o_err=0, loader wen=0, counters and checksum=0. Reset mid-load restarts from CLEAR;
//   SRAM contents already written are not erased, except the RF region.
//  All outputs are registered except o_rx_ready and o_sram_*, which are decoded from state and mux.
//  SRAM mux: in RUN, o_sram_w* = i_core_w*. In any other state the loader drives them and core writes are dropped.
//  CLEAR: one write per cycle: waddr = memsize-RF_BYTES+cnt, wdata=0, wen=1, for cnt=0..RF_BYTES-1.
//   Takes RF_BYTES cycles, then LEN_LO. rx_ready=0.
//  LEN_LO / LEN_HI: rx_ready=1; capture N[7:0], then N[15:8]. Add each byte to the 8-bit checksum sum.
//  On the LEN_HI transfer: N > memsize-RF_BYTES -> ERROR; N==0 -> CSUM; otherwise -> DATA with cnt=0.
//  DATA: rx_ready=1. Each transfer registers a write for the next cycle: waddr=cnt, wdata=byte, wen=1.
//   cnt increments and sum += byte. The transfer with cnt==N-1 moves to CSUM.
//   Sustains 1 byte/cycle. No write occurs in cycles without a transfer. valid gaps are allowed.
//  CSUM: rx_ready=1. On transfer, if (sum+byte) mod 256 == 0 -> RUN, else -> ERROR.
//  RUN: next cycle o_core_rst=0 and o_done=1. rx_ready=0 forever. Stays here until reset.
//  ERROR: o_err=1 next cycle, o_core_rst held 1, rx_ready=0, no SRAM writes. Exit only via reset.
//  Checksum = 8-bit wrap-around sum of len_lo, len_hi, data bytes, csum byte; it must equal 0x00.
//  cnt is 16 bits wide. N == memsize-RF_BYTES exactly is legal and fills addresses 0..N-1.
// TESTING
//  1 Reset, memsize=512: 256 cycles wen=1, wdata=0, waddr 256..511. rx_ready=0 throughout, then 1. core_rst=1.
//  2 Stream 04 00 11 22 33 44 52 -> writes 0:11 1:22 2:33 3:44; done=1 and core_rst=0 cycle after csum.
//  3 Same stream with csum 53 -> err=1, core_rst stays 1, rx_ready=0, no further writes; core wen ignored.
//  4 Length 01 01 (N=257) -> err=1 right after LEN_HI, no DATA writes. Length 00 01 (N=256) accepted.
//  5 Stream 00 00 00 (N=0) -> RUN, done=1. Core wen/waddr/wdata then pass through unchanged to SRAM.
//  6 Random valid gaps plus i_rst_n pulse mid-DATA -> CLEAR restarts, then a full reload succeeds.

Source files
------------

// File: rtl/subservient_loader.sv
// subservient_loader
//   Boot sequencer for the subservient SoC. Keeps the core in reset and owns
//   the SRAM write port while it zeroes the RF region and then loads a
//   length-prefixed, checksummed program from a byte stream into SRAM from
//   address 0. On a good checksum the SRAM write port is handed to the core
//   and core reset is released.
//
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_rx_data/valid, o_rx_ready   program byte stream (transfer = valid & ready)
//   o_core_rst, o_done, o_err     core reset, load-ok (sticky), load-fail (sticky)
//   i_core_w*, i_core_raddr       core SRAM port
//   o_sram_w*, o_sram_raddr       SRAM macro port (loader or core)
//
// state   | meaning
// --------+-------------------------------------------------------------
// CLEAR   | write zero to one RF byte per cycle, RF_BYTES cycles
// LEN_LO  | wait for low length byte
// LEN_HI  | wait for high length byte, range-check N
// DATA    | receive N program bytes, write each one cycle later
// CSUM    | receive checksum byte, decide RUN or ERROR
// RUN     | core owns SRAM write port, core reset released
// ERROR   | load failed, everything quiet until reset
module subservient_loader #(
  parameter int memsize  = 512,
  parameter int aw       = $clog2(memsize),
  parameter int RF_BYTES = 256,
  parameter bit CLEAR_RF = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  output logic          o_core_rst,
  output logic          o_done,
  output logic          o_err,
  input  logic [aw-1:0] i_core_waddr,
  input  logic [7:0]    i_core_wdata,
  input  logic          i_core_wen,
  input  logic [aw-1:0] i_core_raddr,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr
);

  typedef enum logic [2:0] {
    S_CLEAR, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RUN, S_ERROR
  } state_t;

  localparam logic [15:0]   PROG_MAX  = 16'(memsize - RF_BYTES);
  localparam logic [aw-1:0] RF_BASE   = aw'(memsize - RF_BYTES);
  localparam logic [15:0]   CLR_LAST  = 16'(RF_BYTES - 1);
  localparam state_t        RST_STATE = CLEAR_RF ? S_CLEAR : S_LEN_LO;

  state_t        state, state_next;
  logic [15:0]   cnt;
  logic [15:0]   len;
  logic [7:0]    sum;
  logic          core_rst, done, err;
  logic          ld_wen;
  logic [aw-1:0] ld_waddr;
  logic [7:0]    ld_wdata;

  logic          xfer;
  logic [7:0]    sum_add;
  logic [15:0]   len_full;

  assign o_rx_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CSUM);
  assign xfer       = i_rx_valid & o_rx_ready;
  assign sum_add    = sum + i_rx_data;
  assign len_full   = {i_rx_data, len[7:0]};

  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR:  if (cnt == CLR_LAST) state_next = S_LEN_LO;
      S_LEN_LO: if (xfer) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if (len_full > PROG_MAX)   state_next = S_ERROR;
          else if (len_full == '0)   state_next = S_CSUM;
          else                       state_next = S_DATA;
        end
      end
      // len is non-zero here, so len-1 cannot wrap
      S_DATA:   if (xfer && (cnt == len - 16'd1)) state_next = S_CSUM;
      S_CSUM:   if (xfer) state_next = (sum_add == 8'h00) ? S_RUN : S_ERROR;
      default:  state_next = state;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= RST_STATE;
      cnt      <= '0;
      len      <= '0;
      sum      <= '0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      ld_wen   <= 1'b0;
      ld_waddr <= '0;
      ld_wdata <= '0;
    end else begin
      state  <= state_next;
      ld_wen <= 1'b0;
      case (state)
        S_CLEAR: cnt <= (cnt == CLR_LAST) ? '0 : cnt + 16'd1;
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= i_rx_data;
            sum      <= sum_add;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len[15:8] <= i_rx_data;
            sum       <= sum_add;
            cnt       <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            ld_wen   <= 1'b1;
            ld_waddr <= cnt[aw-1:0];
            ld_wdata <= i_rx_data;
            cnt      <= cnt + 16'd1;
            sum      <= sum_add;
          end
        end
        default: ;
      endcase
      if (state_next == S_RUN) begin
        core_rst <= 1'b0;
        done     <= 1'b1;
      end
      if (state_next == S_ERROR) err <= 1'b1;
    end
  end

  assign o_core_rst   = core_rst;
  assign o_done       = done;
  assign o_err        = err;
  assign o_sram_raddr = i_core_raddr;

  // Core writes reach SRAM only in RUN; CLEAR drives the zero-fill directly
  // from cnt so it needs no extra pipeline register.
  always_comb begin
    o_sram_waddr = ld_waddr;
    o_sram_wdata = ld_wdata;
    o_sram_wen   = ld_wen;
    if (state == S_RUN) begin
      o_sram_waddr = i_core_waddr;
      o_sram_wdata = i_core_wdata;
      o_sram_wen   = i_core_wen;
    end else if (state == S_CLEAR) begin
      o_sram_waddr = RF_BASE + cnt[aw-1:0];
      o_sram_wdata = 8'h00;
      o_sram_wen   = 1'b1;
    end
  end

endmodule

// File: tb/tb_subservient_loader.sv
module tb_subservient_loader;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          core_rst, done, err;
  logic [AW-1:0] core_waddr, core_raddr;
  logic [7:0]    core_wdata;
  logic          core_wen;
  logic [AW-1:0] sram_waddr, sram_raddr;
  logic [7:0]    sram_wdata;
  logic          sram_wen;

  always #5 clk = ~clk;

  subservient_loader #(.memsize(512), .RF_BYTES(256), .CLEAR_RF(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_core_rst(core_rst), .o_done(done), .o_err(err),
    .i_core_waddr(core_waddr), .i_core_wdata(core_wdata), .i_core_wen(core_wen),
    .i_core_raddr(core_raddr),
    .o_sram_waddr(sram_waddr), .o_sram_wdata(sram_wdata), .o_sram_wen(sram_wen),
    .o_sram_raddr(sram_raddr)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every SRAM write seen outside reset must match the queue head.
  always @(negedge clk) begin
    if (rst_n && sram_wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %02h expected no write",
                 sram_waddr, sram_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sram_write", {15'd0, sram_waddr, sram_wdata}, {15'd0, e.addr, e.data});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_wr(input int a, input logic [7:0] d);
    exp_q.push_back({AW'(a), d});
  endtask

  // Entered and left just after a posedge.
  task automatic send(input logic [7:0] b, input int gap);
    logic got;
    got = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = rx_ready;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready 0 expected ready 1 for byte %02h", b);
    end
  endtask

  task automatic do_reset();
    int n;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rx_ready", rx_ready, 0);
    @(posedge clk); #1;
    for (int i = 256; i < 512; i++) push_wr(i, 8'h00);
    rst_n = 1'b1;
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
    end
    chk("clear_cycles", n, 256);
    chk("clear_core_rst", core_rst, 1);
    chk("clear_writes_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_run();
    @(negedge clk);
    chk("run_done", done, 1);
    chk("run_core_rst", core_rst, 0);
    chk("run_err", err, 0);
    chk("run_rx_ready", rx_ready, 0);
    @(posedge clk); #1;
  endtask

  logic [7:0] s_ok [7] = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h52};
  logic [7:0] s_bad[7] = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h53};
  int         gaps [7] = '{2, 1, 3, 0, 2, 0, 4};

  task automatic push_ok_writes();
    push_wr(0, 8'h11); push_wr(1, 8'h22); push_wr(2, 8'h33); push_wr(3, 8'h44);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0;
    core_waddr = '0; core_wdata = '0; core_wen = 1'b0; core_raddr = '0;
    @(posedge clk); #1;

    // 1: reset and RF clear
    do_reset();

    // 2: good load
    push_ok_writes();
    for (int i = 0; i < 7; i++) send(s_ok[i], 0);
    check_run();

    // 3: bad checksum, then core writes and stream must be ignored
    do_reset();
    push_ok_writes();
    for (int i = 0; i < 7; i++) send(s_bad[i], 0);
    @(negedge clk);
    chk("csum_err", err, 1);
    chk("csum_core_rst", core_rst, 1);
    chk("csum_done", done, 0);
    chk("csum_rx_ready", rx_ready, 0);
    @(posedge clk); #1;
    core_waddr = 9'd3; core_wdata = 8'hFF; core_wen = 1'b1;
    rx_data = 8'h99; rx_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    core_wen = 1'b0; rx_valid = 1'b0;
    chk("err_writes_left", exp_q.size(), 0);

    // 4a: N=257 rejected right after LEN_HI
    do_reset();
    send(8'h01, 0);
    send(8'h01, 0);
    @(negedge clk);
    chk("len257_err", err, 1);
    chk("len257_rx_ready", rx_ready, 0);
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end

    // 4b: N=256 accepted; data i, sum = 1 + 0x80 = 0x81, csum 0x7F
    do_reset();
    for (int i = 0; i < 256; i++) push_wr(i, 8'(i));
    send(8'h00, 0);
    send(8'h01, 0);
    for (int i = 0; i < 256; i++) send(8'(i), 0);
    send(8'h7F, 0);
    check_run();

    // 5: N=0, then core port passes straight through
    do_reset();
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    check_run();
    push_wr(5, 8'hA5);
    core_waddr = 9'd5; core_wdata = 8'hA5; core_wen = 1'b1; core_raddr = 9'd300;
    @(negedge clk);
    chk("raddr_pass", sram_raddr, 300);
    @(posedge clk); #1;
    core_wen = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // 6: gaps, reset mid-DATA, then full reload with gaps
    do_reset();
    push_wr(0, 8'h11); push_wr(1, 8'h22);
    for (int i = 0; i < 4; i++) send(s_ok[i], gaps[i]);
    @(posedge clk); #1;
    do_reset();
    push_ok_writes();
    for (int i = 0; i < 7; i++) send(s_ok[i], gaps[i]);
    check_run();

    chk("final_writes_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
